// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel APB timer: register offsets,
// control/status bit positions, prescaler select encoding and the tick mask helper.
package timer_pkg;

  localparam logic [2:0] OFF_TDR  = 3'd0;
  localparam logic [2:0] OFF_TCR  = 3'd1;
  localparam logic [2:0] OFF_TSR  = 3'd2;
  localparam logic [2:0] OFF_TCMP = 3'd3;
  localparam logic [2:0] OFF_TIER = 3'd4;

  localparam int TCR_LOAD = 7;
  localparam int TCR_ARLD = 6;
  localparam int TCR_DW   = 5;
  localparam int TCR_EN   = 4;

  localparam int TSR_OVF = 0;
  localparam int TSR_UDF = 1;
  localparam int TSR_CMP = 2;

  typedef enum logic [2:0] {
    CLK_DIV2   = 3'd0,
    CLK_DIV4   = 3'd1,
    CLK_DIV8   = 3'd2,
    CLK_DIV16  = 3'd3,
    CLK_DIV32  = 3'd4,
    CLK_DIV64  = 3'd5,
    CLK_DIV128 = 3'd6,
    CLK_DIV256 = 3'd7
  } clk_sel_e;

  // Low clk_sel+1 bits set; a channel ticks when the prescaler has all of them at 1.
  function automatic logic [7:0] psc_mask(input logic [2:0] sel);
    logic [8:0] m;
    m = (9'd2 << sel) - 9'd1;
    return m[7:0];
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: load/compare/interrupt-enable registers, the up/down counter,
// sticky status flags and the masked level interrupt. Offset 0 reads the live counter.
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       psc,
  input  logic             wr_en,
  input  logic [2:0]       off,
  input  logic [CNT_W-1:0] wdata,
  output logic [CNT_W-1:0] rd_data,
  output logic             irq
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] tdr;
  logic [CNT_W-1:0] tcmp;
  logic             arld;
  logic             dw;
  logic             en;
  clk_sel_e         clk_sel;
  logic             load_pend;
  logic             cmp_hit;
  logic [2:0]       tsr;
  logic [2:0]       tsr_nxt;
  logic [2:0]       tier;
  logic             tick;
  logic             step_up;
  logic             step_dn;
  logic             ovf_set;
  logic             udf_set;

  assign tick    = (psc & psc_mask(clk_sel)) == psc_mask(clk_sel);
  assign step_up = en && tick && !dw && !load_pend;
  assign step_dn = en && tick && dw && !load_pend;
  assign irq     = |(tsr & tier);

  // Next counter value and wrap flags for a prescaler step.
  always_comb begin
    cnt_nxt = cnt;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    if (step_up) begin
      if (&cnt) begin
        cnt_nxt = arld ? tdr : '0;
        ovf_set = 1'b1;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end else if (step_dn) begin
      if (cnt == '0) begin
        cnt_nxt = arld ? tdr : '1;
        udf_set = 1'b1;
      end else begin
        cnt_nxt = cnt - CNT_W'(1);
      end
    end
  end

  // Status update: software write-0 clears, hardware set in the same cycle wins.
  always_comb begin
    tsr_nxt = tsr;
    if (wr_en && off == OFF_TSR) begin
      tsr_nxt = tsr & wdata[2:0];
    end
    tsr_nxt[TSR_OVF] = tsr_nxt[TSR_OVF] | ovf_set;
    tsr_nxt[TSR_UDF] = tsr_nxt[TSR_UDF] | udf_set;
    tsr_nxt[TSR_CMP] = tsr_nxt[TSR_CMP] | cmp_hit;
  end

  // Register readback; the load bit is a strobe and always reads 0.
  always_comb begin
    rd_data = '0;
    case (off)
      OFF_TDR:  rd_data = cnt;
      OFF_TCR:  rd_data[7:0] = {1'b0, arld, dw, en, 1'b0, clk_sel};
      OFF_TSR:  rd_data[2:0] = tsr;
      OFF_TCMP: rd_data = tcmp;
      OFF_TIER: rd_data[2:0] = tier;
      default:  rd_data = '0;
    endcase
  end

  // Counter, pending load/compare strobes and software-visible registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      tdr       <= '0;
      tcmp      <= '0;
      arld      <= 1'b0;
      dw        <= 1'b0;
      en        <= 1'b0;
      clk_sel   <= CLK_DIV2;
      load_pend <= 1'b0;
      cmp_hit   <= 1'b0;
      tsr       <= '0;
      tier      <= '0;
    end else begin
      if (load_pend) begin
        cnt <= tdr;
      end else if (step_up || step_dn) begin
        cnt <= cnt_nxt;
      end
      // Compare is judged on the value a step produces, so a load or a TCMP edit cannot fire it.
      cmp_hit   <= (step_up || step_dn) && (cnt_nxt == tcmp);
      load_pend <= wr_en && (off == OFF_TCR) && wdata[TCR_LOAD];
      tsr       <= tsr_nxt;
      if (wr_en) begin
        case (off)
          OFF_TDR: tdr <= wdata;
          OFF_TCR: begin
            arld    <= wdata[TCR_ARLD];
            dw      <= wdata[TCR_DW];
            en      <= wdata[TCR_EN];
            clk_sel <= clk_sel_e'(wdata[2:0]);
          end
          OFF_TCMP: tcmp <= wdata;
          OFF_TIER: tier <= wdata[2:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/timer_multi_ch.sv
// N-channel APB timer top: address decode, error response, read mux and the
// shared free-running prescaler broadcast to every channel.
module timer_multi_ch
  import timer_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 8
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [CNT_W-1:0]  pwdata,
  output logic [CNT_W-1:0]  prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [N_CH-1:0]   irq
);

  localparam int CH_W = ADDR_W - 3;

  logic [7:0]       psc;
  logic [CH_W-1:0]  ch_idx;
  logic [2:0]       off;
  logic             bad_addr;
  logic [CNT_W-1:0] ch_rd [N_CH];

  assign ch_idx   = paddr[ADDR_W-1:3];
  assign off      = paddr[2:0];
  assign bad_addr = (ch_idx >= CH_W'(N_CH)) || (off > OFF_TIER);
  assign pready   = 1'b1;
  assign pslverr  = psel && penable && bad_addr;

  // Read mux; unmapped addresses and non-read cycles return 0.
  always_comb begin
    prdata = '0;
    if (psel && !pwrite && !bad_addr) begin
      for (int i = 0; i < N_CH; i++) begin
        if (ch_idx == CH_W'(i)) begin
          prdata = ch_rd[i];
        end
      end
    end
  end

  // Shared prescaler, never stopped so enabling a channel does not realign it.
  always_ff @(posedge pclk) begin
    if (preset) begin
      psc <= '0;
    end else begin
      psc <= psc + 8'd1;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic wr_en;
    assign wr_en = psel && penable && pwrite && !bad_addr && (ch_idx == CH_W'(g));

    timer_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk     (pclk),
      .rst     (preset),
      .psc     (psc),
      .wr_en   (wr_en),
      .off     (off),
      .wdata   (pwdata),
      .rd_data (ch_rd[g]),
      .irq     (irq[g])
    );
  end

endmodule

// File: tb/tb_timer_multi_ch.sv
// Scoreboard bench for timer_multi_ch: APB stimulus pushes expected responses
// computed from a cycle-stepped reference model; a monitor pops and compares.
module tb_timer_multi_ch;

  localparam int N_CH   = 4;
  localparam int CNT_W  = 8;
  localparam int ADDR_W = 8;
  localparam int MAXV   = (1 << CNT_W) - 1;

  logic              pclk = 1'b0;
  logic              preset = 1'b1;
  logic              psel = 1'b0;
  logic              penable = 1'b0;
  logic              pwrite = 1'b0;
  logic [ADDR_W-1:0] paddr = '0;
  logic [CNT_W-1:0]  pwdata = '0;
  logic [CNT_W-1:0]  prdata;
  logic              pready;
  logic              pslverr;
  logic [N_CH-1:0]   irq;

  timer_multi_ch #(.N_CH(N_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .pclk    (pclk),
    .preset  (preset),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .irq     (irq)
  );

  always #5 pclk = ~pclk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [CNT_W+1:0] exp_q[$];

  // Reference model state, stepped once per pclk edge from the register rules.
  bit m_live = 1'b0;
  int m_psc;
  int m_cnt[N_CH], m_tdr[N_CH], m_tcmp[N_CH], m_sel[N_CH], m_tsr[N_CH], m_tier[N_CH];
  bit m_arld[N_CH], m_dw[N_CH], m_en[N_CH], m_loadp[N_CH], m_cmpp[N_CH];

  always @(posedge pclk) begin
    int ch, off, div, nv, set;
    bit wr, bad, stepped;
    if (preset) begin
      m_live = 1'b1;
      m_psc  = 0;
      for (int i = 0; i < N_CH; i++) begin
        m_cnt[i] = 0; m_tdr[i] = 0; m_tcmp[i] = 0; m_sel[i] = 0; m_tsr[i] = 0; m_tier[i] = 0;
        m_arld[i] = 0; m_dw[i] = 0; m_en[i] = 0; m_loadp[i] = 0; m_cmpp[i] = 0;
      end
    end else if (m_live) begin
      ch  = int'(paddr) / 8;
      off = int'(paddr) % 8;
      bad = (ch >= N_CH) || (off > 4);
      for (int i = 0; i < N_CH; i++) begin
        wr      = psel && penable && pwrite && !bad && (ch == i);
        div     = 2 << m_sel[i];
        stepped = 1'b0;
        set     = 0;
        nv      = m_cnt[i];
        if (m_loadp[i]) begin
          nv = m_tdr[i];
        end else if (m_en[i] && (m_psc % div) == div - 1) begin
          stepped = 1'b1;
          if (!m_dw[i]) begin
            if (m_cnt[i] == MAXV) begin nv = m_arld[i] ? m_tdr[i] : 0; set = 1; end
            else nv = m_cnt[i] + 1;
          end else begin
            if (m_cnt[i] == 0) begin nv = m_arld[i] ? m_tdr[i] : MAXV; set = 2; end
            else nv = m_cnt[i] - 1;
          end
        end
        if (m_cmpp[i]) set = set | 4;
        m_cmpp[i] = stepped && (nv == m_tcmp[i]);
        m_cnt[i]  = nv;
        if (wr && off == 2) m_tsr[i] = m_tsr[i] & int'(pwdata[2:0]);
        m_tsr[i]   = m_tsr[i] | set;
        m_loadp[i] = wr && (off == 1) && pwdata[7];
        if (wr) begin
          case (off)
            0: m_tdr[i] = int'(pwdata);
            1: begin
              m_arld[i] = pwdata[6]; m_dw[i] = pwdata[5]; m_en[i] = pwdata[4];
              m_sel[i]  = int'(pwdata[2:0]);
            end
            3: m_tcmp[i] = int'(pwdata);
            4: m_tier[i] = int'(pwdata[2:0]);
            default: ;
          endcase
        end
      end
      m_psc = (m_psc + 1) % 256;
    end
  end

  function automatic int exp_rd(input int a);
    int ch, off;
    ch  = a / 8;
    off = a % 8;
    if (ch >= N_CH || off > 4) return 0;
    case (off)
      0: return m_cnt[ch];
      1: return (int'(m_arld[ch]) << 6) | (int'(m_dw[ch]) << 5) | (int'(m_en[ch]) << 4) | m_sel[ch];
      2: return m_tsr[ch];
      3: return m_tcmp[ch];
      default: return m_tier[ch];
    endcase
  endfunction

  // Monitor: irq against the model every cycle; bus response against the queue on each access.
  always @(negedge pclk) begin
    logic [N_CH-1:0]  ei;
    logic [CNT_W+1:0] e;
    if (m_live && !preset) begin
      for (int i = 0; i < N_CH; i++) ei[i] = (m_tsr[i] & m_tier[i]) != 0;
      n_cmp++;
      if (irq !== ei) begin
        n_bad++;
        $display("FAIL irq: got %b want %b at %0t", irq, ei, $time);
      end
      if (psel && penable) begin
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL scoreboard: access at addr %h with no expectation", paddr);
        end else begin
          e = exp_q.pop_front();
          n_cmp++;
          if ({pready, pslverr, prdata} !== e) begin
            n_bad++;
            $display("FAIL apb addr %h wr %0b: got rdy/err/data %b/%b/%h want %b/%b/%h",
                     paddr, pwrite, pready, pslverr, prdata, e[CNT_W+1], e[CNT_W], e[CNT_W-1:0]);
          end
        end
      end
    end
  end

  // Called #1 after an edge; returns #1 after the edge that completes the access.
  task automatic apb(input bit wr, input int a, input int d);
    bit bad;
    psel = 1'b1; pwrite = wr; paddr = ADDR_W'(a); pwdata = CNT_W'(d); penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    bad = ((a / 8) >= N_CH) || ((a % 8) > 4);
    exp_q.push_back({1'b1, bad, wr ? CNT_W'(0) : CNT_W'(exp_rd(a))});
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic wait_cnt(input int ch, input int v, input int lim);
    int k;
    k = 0;
    while (m_cnt[ch] != v && k < lim) begin idle(1); k++; end
    if (m_cnt[ch] != v) begin
      n_cmp++; n_bad++;
      $display("FAIL wait ch%0d: count %0d, required %0d within %0d cycles", ch, m_cnt[ch], v, lim);
    end
  endtask

  function automatic int ad(input int ch, input int off);
    return ch * 8 + off;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, d, k;
    bit wr;
    idle(3);
    preset = 1'b0;

    // reset state
    for (int o = 0; o < 5; o++) apb(0, ad(0, o), 0);
    for (int o = 0; o < 5; o++) apb(0, ad(3, o), 0);

    // ch0 up div2 from 0: no ovf at ~440, ovf by ~520, then software clear
    apb(1, ad(0, 0), 0);
    apb(1, ad(0, 1), 'h80);
    apb(1, ad(0, 1), 'h10);
    idle(432);
    apb(0, ad(0, 2), 0);
    idle(76);
    apb(0, ad(0, 2), 0);
    apb(1, ad(0, 2), 0);
    apb(0, ad(0, 2), 0);

    // ch1 down div16 from 0: underflow then counter at all-ones
    apb(1, ad(1, 1), 'h33);
    idle(20);
    apb(0, ad(1, 2), 0);
    apb(0, ad(1, 0), 0);

    // ch2 auto-reload from 0xF0 up div2
    apb(1, ad(2, 0), 'hF0);
    apb(1, ad(2, 1), 'hD0);
    wait_cnt(2, MAXV, 100);
    idle(2);
    apb(0, ad(2, 0), 0);
    apb(0, ad(2, 2), 0);
    apb(1, ad(2, 2), 0);
    idle(24);
    apb(0, ad(2, 2), 0);

    // ch3 compare 0x40 with cmp interrupt, up div4
    apb(1, ad(3, 3), 'h40);
    apb(1, ad(3, 4), 4);
    apb(1, ad(3, 1), 'h91);
    k = 0;
    while (m_tsr[3] == 0 && k < 400) begin idle(1); k++; end
    if (m_tsr[3] == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL wait ch3 cmp: tsr %0d, required cmp within 400 cycles", m_tsr[3]);
    end
    idle(2);
    apb(0, ad(3, 2), 0);
    apb(1, ad(3, 2), 0);
    apb(0, ad(3, 2), 0);

    // ch0: software clear lands on the overflow edge; the set must win
    apb(1, ad(0, 2), 0);
    apb(1, ad(0, 0), 'hF0);
    apb(1, ad(0, 1), 'h90);
    wait_cnt(0, MAXV, 100);
    if (m_psc % 2 == 0) apb(1, ad(0, 2), 0);
    apb(0, ad(0, 2), 0);

    // error responses
    apb(0, ad(N_CH, 0), 0);
    apb(0, ad(0, 5), 0);
    apb(1, ad(N_CH, 1), 'hFF);
    apb(0, ad(1, 7), 0);
    apb(0, 'hF8, 0);

    // randomized traffic
    for (int n = 0; n < 250; n++) begin
      a  = $urandom_range(0, 39);
      wr = 1'($urandom_range(0, 1));
      d  = $urandom_range(0, 255);
      if (wr && (a % 8) == 1) d = (d & 'hF8) | $urandom_range(0, 2);
      apb(wr, a, d);
      idle($urandom_range(0, 3));
    end

    // reset with everything running, then ch3 isolated from ch0 writes
    for (int c = 0; c < N_CH; c++) begin
      apb(1, ad(c, 4), 7);
      apb(1, ad(c, 0), $urandom_range(0, 255));
      apb(1, ad(c, 1), 'hD0 | (c % 2) * 'h20);
    end
    idle(40);
    preset = 1'b1;
    idle(1);
    preset = 1'b0;
    for (int c = 0; c < N_CH; c++)
      for (int o = 0; o < 5; o++) apb(0, ad(c, o), 0);
    apb(1, ad(3, 1), 'h10);
    apb(1, ad(0, 0), 'h55);
    apb(1, ad(0, 1), 'hB1);
    apb(1, ad(0, 3), 'h12);
    idle(10);
    apb(0, ad(3, 0), 0);
    apb(0, ad(3, 1), 0);
    apb(0, ad(0, 0), 0);

    idle(3);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard drain: %0d left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
